// File: rtl/key_pkg.sv
// Shared constants and FSM encoding for the push-button conditioning block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package key_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_fsm_e;

  // 20 ms window at 50 MHz, minus one
  localparam logic [19:0] DEF_CNT_MAX    = 20'd999_999;
  // 50 debounce periods = 1 s long press
  localparam logic [5:0]  DEF_LONG_TICKS = 6'd50;
  localparam int          KEY_NUM        = 4;

endpackage

// File: rtl/key_filter_one.sv
// Single-key synchronizer + debounce FSM producing press pulse, level and long-press pulse.
// Latency: key_flag rises CNT_MAX+4 edges after the pin is first sampled low.
// Backpressure: none; pin is free-running and outputs are fire-and-forget pulses/levels.
module key_filter_one
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX    = DEF_CNT_MAX,
  parameter logic [5:0]  LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic key_long
);

  logic        key_meta;
  logic        key_sync;
  key_fsm_e    state;
  key_fsm_e    state_nxt;
  logic [19:0] cnt;
  logic [19:0] cnt_nxt;
  logic [5:0]  tick;
  logic [5:0]  tick_nxt;
  logic        flag_nxt;
  logic        long_nxt;

  // Two-flop synchronizer; resets to the released (high) level
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  // FSM, counters and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tick      <= '0;
      key_flag  <= 1'b0;
      key_long  <= 1'b0;
      key_state <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tick      <= tick_nxt;
      key_flag  <= flag_nxt;
      key_long  <= long_nxt;
      key_state <= (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
    end
  end

  // Next-state: qualify press/release over a full window, count long-press periods
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tick_nxt  = tick;
    flag_nxt  = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!key_sync) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          flag_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_nxt = '0;
          // Saturating tick makes the long pulse one-shot per press
          if (tick == LONG_TICKS - 6'd1) long_nxt = 1'b1;
          if (tick != LONG_TICKS)        tick_nxt = tick + 6'd1;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      RELEASE_CHK: begin
        if (!key_sync) begin
          // Release bounce: resume the press, keep accumulated ticks
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          tick_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_filter.sv
// Conditions four active-low board keys into debounced press/level/long-press signals.
// Latency: key_flag rises CNT_MAX+4 edges after a pin is first sampled low.
// Backpressure: none; keys are independent and outputs are unacknowledged pulses/levels.
module key_filter
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX    = DEF_CNT_MAX,
  parameter logic [5:0]  LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_long
);

  // One independent filter per key, no priority between them
  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_filter_one #(
      .CNT_MAX    (CNT_MAX),
      .LONG_TICKS (LONG_TICKS)
    ) u_key (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_in    (key_in[g]),
      .key_flag  (key_flag[g]),
      .key_state (key_state[g]),
      .key_long  (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a run-length behavioural model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_filter;

  localparam int CM = 9;
  localparam int LT = 3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_in;
  logic [3:0] key_flag;
  logic [3:0] key_state;
  logic [3:0] key_long;

  int vectors;
  int miscompares;

  // Model state: per key, pin history and run lengths of synced samples
  logic [3:0] m_pipe0;
  logic [3:0] m_pipe1;
  logic [3:0] m_pressed;
  int         low_run  [4];
  int         high_run [4];
  int         seg      [4];
  int         periods  [4];
  logic [3:0] exp_flag;
  logic [3:0] exp_state;
  logic [3:0] exp_long;

  logic [3:0] acc_flag;
  logic [3:0] acc_long;

  key_filter #(
    .CNT_MAX    (20'(CM)),
    .LONG_TICKS (6'(LT))
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state),
    .key_long  (key_long)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe0   = 4'hF;
    m_pipe1   = 4'hF;
    m_pressed = 4'h0;
    exp_flag  = 4'h0;
    exp_state = 4'h0;
    exp_long  = 4'h0;
    for (int k = 0; k < 4; k++) begin
      low_run[k]  = 0;
      high_run[k] = 0;
      seg[k]      = 0;
      periods[k]  = 0;
    end
  endtask

  // A press needs CM+2 consecutive low synced samples, a release CM+2 highs;
  // each CM+1 uninterrupted held samples completes one long-press period.
  task automatic model_step(input logic [3:0] kin);
    logic s;
    exp_flag = 4'h0;
    exp_long = 4'h0;
    for (int k = 0; k < 4; k++) begin
      s          = m_pipe1[k];
      m_pipe1[k] = m_pipe0[k];
      m_pipe0[k] = kin[k];
      if (!m_pressed[k]) begin
        low_run[k] = s ? 0 : low_run[k] + 1;
        if (low_run[k] == CM + 2) begin
          m_pressed[k] = 1'b1;
          exp_flag[k]  = 1'b1;
          seg[k]       = 0;
          high_run[k]  = 0;
        end
      end else if (!s) begin
        if (high_run[k] != 0) begin
          seg[k] = 0;
        end else begin
          seg[k]++;
          if (seg[k] == CM + 1) begin
            seg[k] = 0;
            if (periods[k] < LT) begin
              periods[k]++;
              if (periods[k] == LT) exp_long[k] = 1'b1;
            end
          end
        end
        high_run[k] = 0;
      end else begin
        seg[k] = 0;
        high_run[k]++;
        if (high_run[k] == CM + 2) begin
          m_pressed[k] = 1'b0;
          periods[k]   = 0;
          low_run[k]   = 0;
        end
      end
    end
    exp_state = m_pressed;
  endtask

  // Compare process: step the model with the pins the DUT just sampled
  always begin
    @(posedge sys_clk);
    #1;
    if (!sys_rst_n) model_reset();
    else            model_step(key_in);
    check("cyc_flag",  key_flag,  exp_flag);
    check("cyc_state", key_state, exp_state);
    check("cyc_long",  key_long,  exp_long);
  end

  // Drive a pin pattern for n cycles, accumulating pulses seen
  task automatic hold(input logic [3:0] v, input int n);
    repeat (n) begin
      @(negedge sys_clk);
      key_in = v;
      @(posedge sys_clk);
      #1;
      acc_flag = acc_flag | key_flag;
      acc_long = acc_long | key_long;
    end
  endtask

  initial begin
    int nflag;
    vectors     = 0;
    miscompares = 0;
    acc_flag    = 4'h0;
    acc_long    = 4'h0;
    model_reset();
    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    #1;
    check("rst_flag",  key_flag,  4'h0);
    check("rst_state", key_state, 4'h0);
    check("rst_long",  key_long,  4'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold(4'hF, 3);

    // 1. Clean press on key 0
    @(negedge sys_clk);
    key_in = 4'b1110;
    repeat (12) @(posedge sys_clk);
    #1;
    check("t1_flag_e12", key_flag, 4'b0000);
    @(posedge sys_clk);
    #1;
    check("t1_flag_e13",  key_flag,  4'b0001);
    check("t1_state_e13", key_state, 4'b0001);
    @(posedge sys_clk);
    #1;
    check("t1_flag_e14",  key_flag,  4'b0000);
    check("t1_state_e14", key_state, 4'b0001);
    hold(4'hF, 16);

    // 2. Bounce reject on key 1
    acc_flag = 4'h0;
    hold(4'b1101, 5);
    hold(4'hF, 3);
    hold(4'b1101, 4);
    hold(4'hF, 15);
    check("t2_noflag", acc_flag,  4'h0);
    check("t2_state",  key_state, 4'h0);

    // 3. Long press on key 2
    @(negedge sys_clk);
    key_in = 4'b1011;
    repeat (13) @(posedge sys_clk);
    #1;
    check("t3_flag", key_flag, 4'b0100);
    repeat (29) @(posedge sys_clk);
    #1;
    check("t3_long_e42", key_long, 4'b0000);
    @(posedge sys_clk);
    #1;
    check("t3_long_e43", key_long, 4'b0100);
    acc_long = 4'h0;
    hold(4'b1011, 100);
    check("t3_no_relong", acc_long,  4'h0);
    check("t3_held",      key_state, 4'b0100);
    hold(4'hF, 16);

    // 4. Release bounce on key 3
    acc_flag = 4'h0;
    hold(4'b0111, 16);
    check("t4_pressed", key_state, 4'b1000);
    hold(4'hF, 4);
    hold(4'b0111, 2);
    hold(4'hF, 12);
    check("t4_still_held", key_state, 4'b1000);
    hold(4'hF, 1);
    check("t4_released", key_state, 4'b0000);
    hold(4'hF, 5);
    nflag = 0;
    if (acc_flag == 4'b1000) nflag = 1;
    check("t4_one_flag", acc_flag, 4'b1000);

    // 5. Simultaneous press on all keys
    @(negedge sys_clk);
    key_in = 4'b0000;
    repeat (13) @(posedge sys_clk);
    #1;
    check("t5_flag",  key_flag,  4'b1111);
    check("t5_state", key_state, 4'b1111);
    @(posedge sys_clk);
    #1;
    check("t5_flag_off", key_flag, 4'b0000);
    hold(4'hF, 16);

    // 6. Reset in the middle of a press on key 0
    hold(4'b1110, 16);
    check("t6_pressed", key_state, 4'b0001);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_state", key_state, 4'b0000);
    check("t6_rst_flag",  key_flag,  4'b0000);
    hold(4'b1110, 3);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12) @(posedge sys_clk);
    #1;
    check("t6_flag_e12", key_flag, 4'b0000);
    @(posedge sys_clk);
    #1;
    check("t6_flag_e13", key_flag, 4'b0001);
    hold(4'hF, 16);

    if (nflag == 0) $display("note: key 3 pulse count differed");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
